i2s_frame_reader: RTL and testbench

I2S_FRAME_READER -- requirements
Module: i2s_frame_reader

---
 rtl/i2s_pkg.sv | 10 +
 rtl/i2s_word_packer.sv | 100 ++++++++++
 rtl/i2s_frame_reader.sv | 142 ++++++++++++++
 tb/tb_i2s_frame_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S capture-RAM frame reader.
package i2s_pkg;
    localparam int FRAME_BITS = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_READ
    } rd_state_t;
endpackage

// File: rtl/i2s_word_packer.sv
// Serial-to-word assembly register plus one holding register feeding the valid/ready output.
module i2s_word_packer
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS = 32,
    parameter int CH_BITS     = 3,
    parameter int FRAME_W     = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   bit_vld_i,
    input  logic                   bit_i,
    input  logic [CH_BITS-1:0]     ch_i,
    input  logic [FRAME_W-1:0]     frame_i,
    output logic                   can_issue_o,
    output logic                   empty_o,
    output logic [SAMPLE_BITS-1:0] sample_o,
    output logic [CH_BITS-1:0]     channel_o,
    output logic [FRAME_W-1:0]     frame_idx_o,
    output logic                   valid_o,
    input  logic                   ready_i
);
    localparam int CNT_W = $clog2(SAMPLE_BITS) + 1;
    localparam int OCC_W = $clog2(SAMPLE_BITS) + 2;

    logic [SAMPLE_BITS-1:0] r_asm, r_hold;
    logic [CNT_W-1:0]       r_asm_cnt;
    logic [CH_BITS-1:0]     r_asm_ch, r_hold_ch;
    logic [FRAME_W-1:0]     r_asm_frame, r_hold_frame;
    logic                   r_hold_vld;

    logic                   w_pop, w_hold_free, w_asm_full, w_last_bit;
    logic [SAMPLE_BITS-1:0] w_shift;
    logic [OCC_W-1:0]       w_occ;

    assign w_pop       = r_hold_vld & ready_i;
    assign w_hold_free = ~r_hold_vld | w_pop;
    assign w_asm_full  = (r_asm_cnt == CNT_W'(SAMPLE_BITS));
    assign w_last_bit  = (r_asm_cnt == CNT_W'(SAMPLE_BITS - 1));
    assign w_shift     = {r_asm[SAMPLE_BITS-2:0], bit_i};

    // Bits held or arriving next cycle; a bit issued now lands one cycle later,
    // so issue only while that bit is guaranteed a slot.
    assign w_occ = ((r_hold_vld & ~w_pop) ? OCC_W'(SAMPLE_BITS) : OCC_W'(0))
                 + OCC_W'(r_asm_cnt) + OCC_W'(bit_vld_i);
    assign can_issue_o = (w_occ < OCC_W'(2 * SAMPLE_BITS));
    assign empty_o     = ~r_hold_vld & (r_asm_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_asm        <= '0;
            r_asm_cnt    <= '0;
            r_asm_ch     <= '0;
            r_asm_frame  <= '0;
            r_hold       <= '0;
            r_hold_ch    <= '0;
            r_hold_frame <= '0;
            r_hold_vld   <= 1'b0;
        end else if (flush_i) begin
            r_asm_cnt  <= '0;
            r_hold_vld <= 1'b0;
        end else begin
            if (w_pop)
                r_hold_vld <= 1'b0;
            if (w_asm_full) begin
                if (w_hold_free) begin
                    r_hold       <= r_asm;
                    r_hold_ch    <= r_asm_ch;
                    r_hold_frame <= r_asm_frame;
                    r_hold_vld   <= 1'b1;
                    r_asm_cnt    <= bit_vld_i ? CNT_W'(1) : CNT_W'(0);
                    if (bit_vld_i) begin
                        r_asm       <= w_shift;
                        r_asm_ch    <= ch_i;
                        r_asm_frame <= frame_i;
                    end
                end
            end else if (bit_vld_i) begin
                if (w_last_bit && w_hold_free) begin
                    r_hold       <= w_shift;
                    r_hold_ch    <= ch_i;
                    r_hold_frame <= frame_i;
                    r_hold_vld   <= 1'b1;
                    r_asm_cnt    <= '0;
                end else begin
                    r_asm       <= w_shift;
                    r_asm_ch    <= ch_i;
                    r_asm_frame <= frame_i;
                    r_asm_cnt   <= r_asm_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign sample_o    = r_hold;
    assign channel_o   = r_hold_ch;
    assign frame_idx_o = r_hold_frame;
    assign valid_o     = r_hold_vld;
endmodule

// File: rtl/i2s_frame_reader.sv
// Streams completed 256-bit frames out of the circular capture RAM as channel words.
// Optional overrun_count_o is built when I2S_READER_OVERRUN_CNT_EN is defined.
module i2s_frame_reader
    import i2s_pkg::*;
#(
    parameter  int CIRC_BUF_BITS = 3,
    parameter  int SAMPLE_BITS   = 32,
    localparam int CH_BITS       = 8 - $clog2(SAMPLE_BITS)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_i,
    output logic [CIRC_BUF_BITS+7:0]   ram_read_addr_o,
    output logic                       ram_read_en_o,
    input  logic                       ram_read_data_i,
    output logic [SAMPLE_BITS-1:0]     sample_o,
    output logic [CH_BITS-1:0]         channel_o,
    output logic [CIRC_BUF_BITS-1:0]   frame_idx_o,
    output logic                       sample_valid_o,
    input  logic                       sample_ready_i,
    output logic                       overrun_o
`ifdef I2S_READER_OVERRUN_CNT_EN
    ,
    output logic [15:0]                overrun_count_o
`endif
);
    localparam int PEND_W = CIRC_BUF_BITS + 1;

    rd_state_t                r_state, w_state_nxt;
    logic [CIRC_BUF_BITS-1:0] r_last_good, r_frame, r_rd_frame;
    logic [7:0]               r_bit;
    logic [PEND_W-1:0]        r_pending;
    logic                     r_rd_pend, r_overrun;
    logic [CH_BITS-1:0]       r_rd_ch;

    logic w_completion, w_overrun, w_hold_off, w_issue, w_frame_end;
    logic w_can_issue, w_pk_empty, w_drained, w_arm_go;

    assign w_completion = (last_good_frame_idx_i != r_last_good);
    assign w_overrun    = (r_state == ST_READ) && w_completion &&
                          (r_pending == PEND_W'((1 << CIRC_BUF_BITS) - 1));
    // Once disabled, finish the frame in progress but never start another.
    assign w_hold_off   = ~enable_i && (r_bit == 8'd0);
    assign w_issue      = (r_state == ST_READ) && (r_pending != '0) && w_can_issue &&
                          ~w_overrun && ~w_hold_off;
    assign w_frame_end  = w_issue && (r_bit == 8'(FRAME_BITS - 1));
    assign w_drained    = ~r_rd_pend && w_pk_empty;
    assign w_arm_go     = (r_state == ST_ARM) && enable_i && w_completion;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (enable_i) w_state_nxt = ST_ARM;
            ST_ARM: begin
                if (!enable_i)         w_state_nxt = ST_IDLE;
                else if (w_completion) w_state_nxt = ST_READ;
            end
            ST_READ: if (w_hold_off && w_drained) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Tracks the writer even through reset so leaving reset never fakes a completion.
    always_ff @(posedge clk_i) r_last_good <= last_good_frame_idx_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_frame    <= '0;
            r_bit      <= '0;
            r_pending  <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_ch    <= '0;
            r_rd_frame <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_pend <= w_issue;
            r_overrun <= w_overrun;
            if (w_issue) begin
                r_rd_ch    <= r_bit[7:8-CH_BITS];
                r_rd_frame <= r_frame;
            end
            if (w_arm_go || w_overrun) begin
                r_frame   <= last_good_frame_idx_i;
                r_bit     <= '0;
                r_pending <= PEND_W'(1);
            end else if (r_state == ST_READ) begin
                if (w_issue) begin
                    r_bit <= r_bit + 8'd1;
                    if (w_frame_end)
                        r_frame <= r_frame + CIRC_BUF_BITS'(1);
                end
                if (w_state_nxt == ST_IDLE)
                    r_pending <= '0;
                else if (w_completion && !w_frame_end)
                    r_pending <= r_pending + PEND_W'(1);
                else if (!w_completion && w_frame_end)
                    r_pending <= r_pending - PEND_W'(1);
            end else begin
                r_pending <= '0;
            end
        end
    end

`ifdef I2S_READER_OVERRUN_CNT_EN
    logic [15:0] r_ovr_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_ovr_cnt <= '0;
        else if (w_overrun && r_ovr_cnt != 16'hFFFF)
            r_ovr_cnt <= r_ovr_cnt + 16'd1;
    end
    assign overrun_count_o = r_ovr_cnt;
`endif

    i2s_word_packer #(
        .SAMPLE_BITS (SAMPLE_BITS),
        .CH_BITS     (CH_BITS),
        .FRAME_W     (CIRC_BUF_BITS)
    ) u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (w_overrun),
        .bit_vld_i   (r_rd_pend),
        .bit_i       (ram_read_data_i),
        .ch_i        (r_rd_ch),
        .frame_i     (r_rd_frame),
        .can_issue_o (w_can_issue),
        .empty_o     (w_pk_empty),
        .sample_o    (sample_o),
        .channel_o   (channel_o),
        .frame_idx_o (frame_idx_o),
        .valid_o     (sample_valid_o),
        .ready_i     (sample_ready_i)
    );

    assign ram_read_addr_o = {r_frame, r_bit};
    assign ram_read_en_o   = w_issue;
    assign overrun_o       = r_overrun;
endmodule

// File: tb/tb_i2s_frame_reader.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor pops on each handshake.
module tb_i2s_frame_reader;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [2:0]  last_good = 3'd0;
    logic [10:0] ram_read_addr_o;
    logic        ram_read_en_o;
    logic        ram_read_data_i = 1'b0;
    logic [31:0] sample_o;
    logic [2:0]  channel_o;
    logic [2:0]  frame_idx_o;
    logic        sample_valid_o;
    logic        sample_ready_i = 1'b1;
    logic        overrun_o;
`ifdef I2S_READER_OVERRUN_CNT_EN
    logic [15:0] overrun_count_o;
`endif

    always #5 clk = ~clk;

    i2s_frame_reader #(.CIRC_BUF_BITS(3), .SAMPLE_BITS(32)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .enable_i              (enable_i),
        .last_good_frame_idx_i (last_good),
        .ram_read_addr_o       (ram_read_addr_o),
        .ram_read_en_o         (ram_read_en_o),
        .ram_read_data_i       (ram_read_data_i),
        .sample_o              (sample_o),
        .channel_o             (channel_o),
        .frame_idx_o           (frame_idx_o),
        .sample_valid_o        (sample_valid_o),
        .sample_ready_i        (sample_ready_i),
        .overrun_o             (overrun_o)
`ifdef I2S_READER_OVERRUN_CNT_EN
        ,
        .overrun_count_o       (overrun_count_o)
`endif
    );

    typedef struct {
        logic [31:0] s;
        logic [2:0]  ch;
        logic [2:0]  f;
    } exp_t;

    exp_t        q[$];
    logic        mem [0:2047];
    int          en_cyc [0:2047];
    int          errors = 0, checks = 0;
    int          cyc = 0, en_count = 0, ovr_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] p_s;
    logic [2:0]  p_ch, p_f;

    function automatic logic [31:0] exp_word(input int f, input int w);
        if (f == 2) return 32'hA5A5A5A5;
        return {8'(f + 48), 8'(w + 64), 8'(f) ^ 8'h5A, 8'(w * 17 + 3)};
    endfunction

    // Capture RAM: data returns one cycle after the strobe.
    always @(posedge clk) if (ram_read_en_o) ram_read_data_i <= mem[ram_read_addr_o];

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (ram_read_en_o) begin
            en_cyc[ram_read_addr_o] = cyc;
            en_count++;
        end
        if (overrun_o) ovr_seen++;
        if (prev_stall && !overrun_o) begin
            checks++;
            if (!sample_valid_o || sample_o != p_s || channel_o != p_ch || frame_idx_o != p_f) begin
                errors++;
                $display("FAIL stall_hold: got v=%0b %h ch%0d f%0d, need v=1 %h ch%0d f%0d",
                         sample_valid_o, sample_o, channel_o, frame_idx_o, p_s, p_ch, p_f);
            end
        end
        if (sample_valid_o && sample_ready_i) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected: got %h ch%0d f%0d, need none", sample_o, channel_o, frame_idx_o);
            end else begin
                e = q.pop_front();
                if (sample_o != e.s || channel_o != e.ch || frame_idx_o != e.f) begin
                    errors++;
                    $display("FAIL word: got %h ch%0d f%0d, need %h ch%0d f%0d",
                             sample_o, channel_o, frame_idx_o, e.s, e.ch, e.f);
                end
            end
        end
        prev_stall = sample_valid_o && !sample_ready_i && !rst_i;
        p_s = sample_o; p_ch = channel_o; p_f = frame_idx_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int f);
        exp_t e;
        for (int w = 0; w < 8; w++) begin
            e.s = exp_word(f, w); e.ch = 3'(w); e.f = 3'(f);
            q.push_back(e);
        end
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        tick(4);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words outstanding, need 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_eq(input string name, input int got, input int need);
        checks++;
        if (got != need) begin
            errors++;
            $display("FAIL %s: got %0d, need %0d", name, got, need);
        end
    endtask

    task automatic check_zero(input string name);
        @(negedge clk);
        #1;
        checks++;
        if ({ram_read_en_o, sample_valid_o, overrun_o} != 3'b0 || ram_read_addr_o != 11'd0 ||
            sample_o != 32'd0 || channel_o != 3'd0 || frame_idx_o != 3'd0) begin
            errors++;
            $display("FAIL %s: got en=%0b v=%0b ovr=%0b addr=%h s=%h ch=%0d f=%0d, need all 0", name,
                     ram_read_en_o, sample_valid_o, overrun_o, ram_read_addr_o, sample_o, channel_o, frame_idx_o);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int e0, o0;
        int seq [8] = '{6, 7, 0, 1, 2, 3, 4, 5};
        for (int i = 0; i < 2048; i++) begin
            w = exp_word(i / 256, (i % 256) / 32);
            mem[i] = w[31 - (i % 32)];
            en_cyc[i] = 0;
        end

        tick(3);
        check_zero("reset_state");
        rst_i = 1'b0;
        tick(2);
        enable_i = 1'b1;
        tick(3);

        // first completion after enable: frame 1 in full
        e0 = en_count;
        last_good = 3'd1;
        push_frame(1);
        wait_empty("frame1");
        check_eq("frame1_reads", en_count - e0, 256);
        check_eq("frame1_span", en_cyc[256 + 255] - en_cyc[256], 255);

        last_good = 3'd2;
        push_frame(2);
        wait_empty("frame2");
        check_eq("frame2_no_gap", en_cyc[512 + 255] - en_cyc[512], 255);

        // completions 256 cycles apart read back-to-back
        last_good = 3'd3;
        push_frame(3);
        tick(256);
        last_good = 3'd4;
        push_frame(4);
        wait_empty("frame34");
        check_eq("frame3_to_4", en_cyc[1024] - en_cyc[768 + 255], 1);

        // long back-pressure mid-frame
        last_good = 3'd5;
        push_frame(5);
        tick(100);
        sample_ready_i = 1'b0;
        tick(300);
        sample_ready_i = 1'b1;
        wait_empty("stall");

        // eight completions with ready low: the last overruns
        o0 = ovr_seen;
        sample_ready_i = 1'b0;
        foreach (seq[i]) begin
            last_good = 3'(seq[i]);
            tick(2);
        end
        push_frame(5);
        tick(20);
        sample_ready_i = 1'b1;
        wait_empty("overrun");
        check_eq("overrun_pulses", ovr_seen - o0, 1);
`ifdef I2S_READER_OVERRUN_CNT_EN
        check_eq("overrun_count", int'(overrun_count_o), 1);
`endif

        // reset mid-frame, then resume; enable drop finishes the frame
        last_good = 3'd6;
        sample_ready_i = 1'b0;
        tick(100);
        rst_i = 1'b1;
        tick(1);
        check_zero("reset_mid_frame");
        q.delete();
        tick(1);
        rst_i = 1'b0;
        tick(3);
        last_good = 3'd7;
        push_frame(7);
        sample_ready_i = 1'b1;
        tick(60);
        enable_i = 1'b0;
        wait_empty("enable_drop");
        e0 = en_count;
        last_good = 3'd0;
        tick(300);
        check_eq("idle_no_reads", en_count - e0, 0);
        check_eq("idle_no_words", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
